nonce_reporter: RTL

//  Consumes golden-nonce hits from the miner datapath, queues them in a small FIFO and

---
 rtl/nonce_reporter_if.sv | 31 +++
 rtl/nonce_reporter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_reporter_if.sv
// nonce_reporter_if
//   Bundles the signals between the miner datapath, nonce_reporter and conn_core.
//   master : the side that produces hits and control (datapath / bench)
//   slave  : nonce_reporter itself
//   nonce_valid/nonce  hit strobe and value
//   miner/cur_nonce    mining-enable level and current search nonce (heartbeat)
//   flush              discard all queued hits
//   msg/delivery_msg   formatted line and its presence level for conn_core
//   busy/fifo_count/dropped_cnt  status
interface nonce_reporter_if;
  logic          nonce_valid;
  logic [31:0]   nonce;
  logic          miner;
  logic [31:0]   cur_nonce;
  logic          flush;
  logic [1023:0] msg;
  logic          delivery_msg;
  logic          busy;
  logic [4:0]    fifo_count;
  logic [7:0]    dropped_cnt;

  modport master (
    output nonce_valid, nonce, miner, cur_nonce, flush,
    input  msg, delivery_msg, busy, fifo_count, dropped_cnt
  );

  modport slave (
    input  nonce_valid, nonce, miner, cur_nonce, flush,
    output msg, delivery_msg, busy, fifo_count, dropped_cnt
  );
endinterface

// File: rtl/nonce_reporter.sv
// nonce_reporter
//   Queues golden-nonce hits in a small FIFO and turns each one into the ASCII
//   line "N:XXXXXXXX^" on bus.msg, announced to conn_core by holding
//   bus.delivery_msg high for HOLD_CYCLES, followed by a GAP_CYCLES quiet period.
//   Optional build macro NONCE_REPORTER_HEARTBEAT_EN adds a periodic "S:XXXXXXXX^"
//   status line carrying cur_nonce while mining; without it miner/cur_nonce are ignored.
// Ports
//   CLOCK_50  system clock
//   reset     asynchronous, active-low
//   bus       nonce_reporter_if.slave (hit input, flush, msg/delivery_msg, status)
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for a queued hit (or pending heartbeat)
// S_LOAD   | clear msg, write prefix tag and ':'
// S_FORMAT | write one hex digit per cycle (8 cycles), then '^'
// S_PRESENT| delivery_msg high for HOLD_CYCLES
// S_GAP    | delivery_msg low for GAP_CYCLES before accepting the next line
module nonce_reporter #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 200000,
  parameter int unsigned GAP_CYCLES  = 64,
  parameter int unsigned HB_CYCLES   = 50000000
) (
  input logic             CLOCK_50,
  input logic             reset,
  nonce_reporter_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FORMAT, S_PRESENT, S_GAP} state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  state_t         state_q, state_d;
  logic [31:0]    fifo_q [FIFO_DEPTH];
  logic [31:0]    fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]     count_q, count_d;
  logic [7:0]     dropped_q, dropped_d;
  logic [31:0]    sr_q, sr_d;
  logic [2:0]     nib_q, nib_d;
  logic [31:0]    timer_q, timer_d;
  logic [7:0]     tag_q, tag_d;
  logic [1023:0]  msg_q, msg_d;
  logic           deliv_q, deliv_d;
  logic           busy_q, busy_d;

  logic           push, pop, full, push_ok;
  logic [9:0]     byte_lsb;

  // flush beats both a same-cycle push and an idle pop: nothing queued survives it
  assign push    = bus.nonce_valid && !bus.flush;
  assign pop     = (state_q == S_IDLE) && (count_q != 5'd0) && !bus.flush;
  assign full    = (count_q == 5'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);
  assign byte_lsb = {4'd0, nib_q, 3'b000} + 10'd16;

`ifdef NONCE_REPORTER_HEARTBEAT_EN
  logic [31:0] hb_cnt_q, hb_cnt_d;
  logic        hb_pend_q, hb_pend_d;
  logic        hb_start;

  assign hb_start = (state_q == S_IDLE) && (count_q == 5'd0) && !bus.flush && hb_pend_q;
`else
  localparam int unsigned unused_hb_cycles = HB_CYCLES;
  logic unused_hb_inputs;
  assign unused_hb_inputs = ^{bus.miner, bus.cur_nonce};
`endif

  always_comb begin
    state_d   = state_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    sr_d      = sr_q;
    nib_d     = nib_q;
    timer_d   = timer_q;
    tag_d     = tag_q;
    msg_d     = msg_q;
    deliv_d   = deliv_q;

    if (push && full && !pop && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
    if (push_ok) begin
      fifo_d[wr_ptr_q] = bus.nonce;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (bus.flush) begin
      count_d  = 5'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + 5'(push_ok) - 5'(pop);
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sr_d    = fifo_q[rd_ptr_q];
          tag_d   = 8'h4E;
          state_d = S_LOAD;
        end
`ifdef NONCE_REPORTER_HEARTBEAT_EN
        else if (hb_start) begin
          sr_d    = bus.cur_nonce;
          tag_d   = 8'h53;
          state_d = S_LOAD;
        end
`endif
      end
      S_LOAD: begin
        msg_d        = '0;
        msg_d[7:0]   = tag_q;
        msg_d[15:8]  = 8'h3A;
        nib_d        = 3'd0;
        state_d      = S_FORMAT;
      end
      S_FORMAT: begin
        msg_d[byte_lsb +: 8] = hex_char(sr_q[31:28]);
        sr_d  = {sr_q[27:0], 4'h0};
        nib_d = nib_q + 3'd1;
        if (nib_q == 3'd7) begin
          msg_d[87:80] = 8'h5E;
          deliv_d      = 1'b1;
          timer_d      = 32'(HOLD_CYCLES - 1);
          state_d      = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (timer_q == 32'd0) begin
          deliv_d = 1'b0;
          timer_d = 32'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_GAP: begin
        if (timer_q == 32'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

`ifdef NONCE_REPORTER_HEARTBEAT_EN
  // a fresh terminal count wins over the clear from a heartbeat just taken
  always_comb begin
    hb_cnt_d  = hb_cnt_q;
    hb_pend_d = hb_pend_q;
    if (hb_start) begin
      hb_pend_d = 1'b0;
    end
    if (!bus.miner) begin
      hb_cnt_d = 32'd0;
    end else if (hb_cnt_q == 32'(HB_CYCLES - 1)) begin
      hb_cnt_d  = 32'd0;
      hb_pend_d = 1'b1;
    end else begin
      hb_cnt_d = hb_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hb_cnt_q  <= 32'd0;
      hb_pend_q <= 1'b0;
    end else begin
      hb_cnt_q  <= hb_cnt_d;
      hb_pend_q <= hb_pend_d;
    end
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 32'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 5'd0;
      dropped_q <= 8'd0;
      sr_q      <= 32'd0;
      nib_q     <= 3'd0;
      timer_q   <= 32'd0;
      tag_q     <= 8'd0;
      msg_q     <= '0;
      deliv_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      sr_q      <= sr_d;
      nib_q     <= nib_d;
      timer_q   <= timer_d;
      tag_q     <= tag_d;
      msg_q     <= msg_d;
      deliv_q   <= deliv_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.msg          = msg_q;
  assign bus.delivery_msg = deliv_q;
  assign bus.busy         = busy_q;
  assign bus.fifo_count   = count_q;
  assign bus.dropped_cnt  = dropped_q;
endmodule
